// File: rtl/fft_mult_pkg.sv
// Shared constants for the W8 twiddle (half-sqrt2) multiplier used by the
// 64-point FFT butterfly stages.
package fft_mult_pkg;

  // 2896 / 4096 ~= 0.70703 ~= 1/sqrt(2)
  localparam int HALFSQRT2_COEF  = 2896;
  localparam int HALFSQRT2_SHIFT = 12;

  // Q1.15 sample width
  localparam int DATA_W = 16;

endpackage

// File: rtl/halfsqrt2_mult_arbiter_if.sv
// Requester/operand side and product side handshake bundle of the shared
// half-sqrt2 multiplier.
interface halfsqrt2_mult_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int ID_W    = 2
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic [ID_W-1:0]           out_id;
  logic                      out_ready;

  // master: requesters plus the downstream consumer
  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );

  // slave: the shared multiplier
  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id
  );

endinterface

// File: rtl/halfsqrt2_rr_arb.sv
// Round-robin arbiter: one-hot grant searched upward from a rotating pointer,
// encoded grant index and accept strobe; the pointer moves past each winner.
module halfsqrt2_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               accept
);

  logic [ID_W-1:0]                ptr_reg;
  logic [ID_W-1:0]                ptr_next;
  logic [2*NUM_REQ-1:0]           req_dbl;
  logic [2*NUM_REQ-1:0]           grant_dbl;
  logic [NUM_REQ-1:0]             rot_req;
  logic [NUM_REQ-1:0]             seen;
  logic [NUM_REQ-1:0]             rot_first;
  logic [NUM_REQ-1:0]             grant_raw;
  logic [NUM_REQ-1:0][ID_W-1:0]   id_acc;

  // Rotate so the pointer position becomes bit 0, pick the lowest set bit,
  // then rotate the winner back into requester order.
  assign req_dbl   = {req_valid, req_valid} >> ptr_reg;
  assign rot_req   = req_dbl[NUM_REQ-1:0];
  assign grant_dbl = {rot_first, rot_first} << ptr_reg;
  assign grant_raw = grant_dbl[2*NUM_REQ-1:NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_pick
      if (gi == 0) begin : g_first
        assign seen[gi]      = rot_req[gi];
        assign rot_first[gi] = rot_req[gi];
        assign id_acc[gi]    = grant_raw[gi] ? ID_W'(gi) : '0;
      end else begin : g_rest
        assign seen[gi]      = seen[gi-1] | rot_req[gi];
        assign rot_first[gi] = rot_req[gi] & ~seen[gi-1];
        assign id_acc[gi]    = id_acc[gi-1] | (grant_raw[gi] ? ID_W'(gi) : '0);
      end
    end
  endgenerate

  assign grant_id = id_acc[NUM_REQ-1];
  assign accept   = en & (|req_valid);
  assign grant    = en ? grant_raw : '0;

  assign ptr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else if (accept) begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/halfsqrt2_mult_arbiter.sv
// One half-sqrt2 constant multiplier shared by NUM_REQ requesters: round-robin
// accept, stallable MULT_LAT-stage pipeline, id-tagged output with backpressure.
module halfsqrt2_mult_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 16,
  parameter int MULT_LAT = 2,
  parameter int ID_W     = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  halfsqrt2_mult_arbiter_if.slave   bus,
  output logic                      busy
);

  import fft_mult_pkg::*;

  localparam int PW = DATA_W + HALFSQRT2_SHIFT;

  // Sign-magnitude multiply by 2896/4096; truncating the magnitude keeps the
  // rounding symmetric around zero. Shift terms sum to HALFSQRT2_COEF.
  function automatic logic [DATA_W-1:0] halfsqrt2_mul(input logic [DATA_W-1:0] x);
    logic              s;
    logic [DATA_W-1:0] m;
    logic [PW-1:0]     mw;
    logic [PW-1:0]     p;
    logic [DATA_W-1:0] r;
    s  = x[DATA_W-1];
    m  = s ? (~x + DATA_W'(1)) : x;
    mw = PW'(m);
    p  = (mw << 11) + (mw << 9) + (mw << 8) + (mw << 6) + (mw << 4);
    r  = p[PW-1:HALFSQRT2_SHIFT];
    return s ? (~r + DATA_W'(1)) : r;
  endfunction

  logic                               adv;
  logic [NUM_REQ-1:0]                 grant;
  logic [ID_W-1:0]                    grant_id;
  logic                               accept;
  logic [NUM_REQ-1:0][DATA_W-1:0]     sel_acc;
  logic [DATA_W-1:0]                  sel_data;

  logic [MULT_LAT-1:0]                valid_reg;
  logic [MULT_LAT-1:0]                valid_next;
  logic [MULT_LAT-1:0][ID_W-1:0]      id_reg;
  logic [MULT_LAT-1:0][ID_W-1:0]      id_next;
  logic [MULT_LAT-1:0][DATA_W-1:0]    data_reg;
  logic [MULT_LAT-1:0][DATA_W-1:0]    data_next;

  assign adv = !valid_reg[MULT_LAT-1] || bus.out_ready;

  // Gating with rst_n keeps req_ready low while reset is held.
  halfsqrt2_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (adv && rst_n),
    .req_valid (bus.req_valid),
    .grant     (grant),
    .grant_id  (grant_id),
    .accept    (accept)
  );

  assign bus.req_ready = grant;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_sel
      if (gi == 0) begin : g_first
        assign sel_acc[gi] = grant[gi] ? bus.req_data[gi*DATA_W +: DATA_W] : '0;
      end else begin : g_rest
        assign sel_acc[gi] = sel_acc[gi-1] |
                             (grant[gi] ? bus.req_data[gi*DATA_W +: DATA_W] : '0);
      end
    end
  endgenerate

  assign sel_data = sel_acc[NUM_REQ-1];

  // The product is formed between stage 1 and stage 2, or ahead of stage 1
  // when the pipeline is a single register deep.
  generate
    for (gi = 0; gi < MULT_LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign valid_next[gi] = accept;
        assign id_next[gi]    = grant_id;
        if (MULT_LAT == 1) begin : g_mul_in
          assign data_next[gi] = halfsqrt2_mul(sel_data);
        end else begin : g_raw_in
          assign data_next[gi] = sel_data;
        end
      end else begin : g_body
        assign valid_next[gi] = valid_reg[gi-1];
        assign id_next[gi]    = id_reg[gi-1];
        if (gi == 1) begin : g_mul
          assign data_next[gi] = halfsqrt2_mul(data_reg[gi-1]);
        end else begin : g_shift
          assign data_next[gi] = data_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      id_reg    <= '0;
      data_reg  <= '0;
    end else if (adv) begin
      valid_reg <= valid_next;
      id_reg    <= id_next;
      data_reg  <= data_next;
    end
  end

  assign bus.out_valid = valid_reg[MULT_LAT-1];
  assign bus.out_data  = data_reg[MULT_LAT-1];
  assign bus.out_id    = id_reg[MULT_LAT-1];
  assign busy          = |valid_reg;

endmodule

// File: tb/tb_halfsqrt2_mult_arbiter.sv
// Randomized and directed bench for halfsqrt2_mult_arbiter against a
// transaction-level reference model (arithmetic product, pointer search).
module tb_halfsqrt2_mult_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int DATA_W   = 16;
  localparam int MULT_LAT = 2;
  localparam int ID_W     = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  halfsqrt2_mult_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  halfsqrt2_mult_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .DATA_W   (DATA_W),
    .MULT_LAT (MULT_LAT),
    .ID_W     (ID_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  typedef struct {
    bit v;
    int id;
    int data;
  } slot_t;

  slot_t pipe [MULT_LAT];
  int    ptr_m;
  int    last_gid;
  int    obs_id [$];
  int    obs_data [$];

  function automatic int ref_mul(input int x);
    int a;
    a = (x < 0) ? -x : x;
    a = (a * 2896) / 4096;
    return (x < 0) ? -a : a;
  endfunction

  function automatic logic [DATA_W-1:0] to16(input int x);
    return x[DATA_W-1:0];
  endfunction

  function automatic logic [NUM_REQ*DATA_W-1:0] pack4(input int a0, input int a1,
                                                     input int a2, input int a3);
    logic [NUM_REQ*DATA_W-1:0] r;
    r[0*DATA_W +: DATA_W] = a0[DATA_W-1:0];
    r[1*DATA_W +: DATA_W] = a1[DATA_W-1:0];
    r[2*DATA_W +: DATA_W] = a2[DATA_W-1:0];
    r[3*DATA_W +: DATA_W] = a3[DATA_W-1:0];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < MULT_LAT; k++) pipe[k] = '{1'b0, 0, 0};
    ptr_m = 0;
  endtask

  task automatic clear_obs();
    obs_id.delete();
    obs_data.delete();
  endtask

  // One clock: drive at negedge, compare at negedge+1, advance model at posedge.
  task automatic step(input logic [NUM_REQ-1:0] v, input logic [NUM_REQ*DATA_W-1:0] d,
                      input logic ordy);
    int                 gid;
    bit                 adv_m;
    bit                 any_v;
    logic [NUM_REQ-1:0] exp_rdy;
    int                 x;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_data  = d;
    bus.out_ready = ordy;
    #1;
    adv_m = !pipe[MULT_LAT-1].v || ordy;
    gid = -1;
    if (adv_m) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int idx;
        idx = (ptr_m + k) % NUM_REQ;
        if (gid < 0 && v[idx]) gid = idx;
      end
    end
    exp_rdy = (gid >= 0) ? NUM_REQ'(1 << gid) : '0;
    any_v = 1'b0;
    for (int k = 0; k < MULT_LAT; k++) any_v |= pipe[k].v;
    check_val("req_ready", bus.req_ready, exp_rdy);
    check_val("out_valid", bus.out_valid, pipe[MULT_LAT-1].v);
    check_val("busy", busy, any_v);
    if (pipe[MULT_LAT-1].v) begin
      check_val("out_id", bus.out_id, pipe[MULT_LAT-1].id);
      check_val("out_data", bus.out_data, to16(pipe[MULT_LAT-1].data));
    end
    if (bus.out_valid && ordy) begin
      obs_id.push_back(int'(bus.out_id));
      obs_data.push_back(int'($signed(bus.out_data)));
    end
    last_gid = gid;
    @(posedge clk);
    if (adv_m) begin
      for (int k = MULT_LAT - 1; k > 0; k--) pipe[k] = pipe[k-1];
      if (gid >= 0) begin
        x = $signed(d[gid*DATA_W +: DATA_W]);
        pipe[0] = '{1'b1, gid, ref_mul(x)};
        ptr_m = (gid + 1) % NUM_REQ;
      end else begin
        pipe[0] = '{1'b0, 0, 0};
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, '0, 1'b1);
  endtask

  task automatic check_obs(input string tag, input int exp_n, input int exp_ids[],
                           input int exp_data[]);
    check_val({tag, "_count"}, obs_id.size(), exp_n);
    for (int i = 0; i < exp_n && i < obs_id.size(); i++) begin
      check_val({tag, "_id"}, obs_id[i], exp_ids[i]);
      check_val({tag, "_data"}, obs_data[i], exp_data[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int                        fair_ids[];
    int                        fair_data[];
    int                        edge_in[];
    int                        edge_exp[];
    int                        ids[];
    int                        q[$];
    logic [NUM_REQ*DATA_W-1:0] d;
    logic [NUM_REQ-1:0]        v;
    logic                      ordy;

    model_reset();
    bus.req_valid = '1;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    #12;
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_out_data", bus.out_data, 0);
    check_val("rst_out_id", bus.out_id, 0);
    check_val("rst_req_ready", bus.req_ready, 0);
    check_val("rst_busy", busy, 0);
    @(negedge clk);
    bus.req_valid = '0;
    #2 rst_n = 1'b1;

    // Fairness: all four requesters valid for eight cycles
    clear_obs();
    d = pack4(0, 1000, 2000, 3000);
    for (int k = 0; k < 8; k++) begin
      step(4'hF, d, 1'b1);
      check_val("fair_grant", last_gid, k % 4);
    end
    idle(3);
    fair_ids  = '{0, 1, 2, 3, 0, 1, 2, 3};
    fair_data = '{0, 707, 1414, 2121, 0, 707, 1414, 2121};
    check_obs("fair", 8, fair_ids, fair_data);

    // Single accept
    clear_obs();
    step(4'b0001, pack4(16384, 0, 0, 0), 1'b1);
    check_val("single_grant", last_gid, 0);
    idle(3);
    check_obs("single", 1, '{0}, '{11584});

    // Signed edge values from requester 2; 0x8000 has magnitude 32768 -> 8*2896
    clear_obs();
    edge_in  = '{-16384, 32767, -32768, 1, -1, 0};
    edge_exp = '{-11584, 23167, -23168, 0, 0, 0};
    foreach (edge_in[i]) step(4'b0100, pack4(0, 0, edge_in[i], 0), 1'b1);
    idle(3);
    ids = '{2, 2, 2, 2, 2, 2};
    check_obs("edge", 6, ids, edge_exp);

    // Sparse requests with pointer wrap
    d = pack4(11, 22, 33, 44);
    step(4'b1000, d, 1'b1);
    check_val("sparse_grant0", last_gid, 3);
    step(4'b0001, d, 1'b1);
    check_val("sparse_grant1", last_gid, 0);
    step(4'b1001, d, 1'b1);
    check_val("sparse_grant2", last_gid, 3);
    idle(3);

    // Backpressure: requester 1 streams, consumer stalls for three cycles
    clear_obs();
    q = '{4096, 8192, 12288, 16384, 20480};
    for (int c = 0; c < 14; c++) begin
      ordy = !(c >= 2 && c < 5);
      v    = (q.size() > 0) ? 4'b0010 : 4'b0000;
      d    = pack4(0, (q.size() > 0) ? q[0] : 0, 0, 0);
      step(v, d, ordy);
      if (c >= 2 && c < 5) check_val("stall_ready", bus.req_ready, 0);
      if (last_gid == 1) void'(q.pop_front());
    end
    check_obs("bp", 5, '{1, 1, 1, 1, 1}, '{2896, 5792, 8688, 11584, 14480});

    // Randomized traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      v    = NUM_REQ'($urandom_range(0, 15));
      d    = {$urandom(), $urandom()};
      ordy = ($urandom_range(0, 3) != 0);
      step(v, d, ordy);
    end
    idle(4);

    // Reset mid-flight
    d = pack4(100, 200, 300, 400);
    step(4'hF, d, 1'b1);
    step(4'hF, d, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_out_valid", bus.out_valid, 0);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_req_ready", bus.req_ready, 0);
    check_val("midrst_out_data", bus.out_data, 0);
    model_reset();
    bus.req_valid = '0;
    #1 rst_n = 1'b1;
    clear_obs();
    step(4'hF, d, 1'b1);
    check_val("post_rst_grant", last_gid, 0);
    idle(4);
    check_obs("post_rst", 1, '{0}, '{70});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
